// File: rtl/fly_wave_scheduler_if.sv
// Handshake/status bundle between game control, collision logic and the
// fly wave scheduler. The scheduler uses the slave view; the control side
// (or a bench) uses the master view.
interface fly_wave_scheduler_if #(
  parameter int N_FLY = 17
);
  logic             start;
  logic             kill_valid;
  logic [4:0]       kill_idx;
  logic             kill_ready;
  logic             move_tick;
  logic             spawn_valid;
  logic [4:0]       spawn_idx;
  logic [N_FLY-1:0] fly_alive_flat;
  logic [7:0]       wave_num;
  logic             busy;

  modport master (
    output start, kill_valid, kill_idx,
    input  kill_ready, move_tick, spawn_valid, spawn_idx,
    input  fly_alive_flat, wave_num, busy
  );

  modport slave (
    input  start, kill_valid, kill_idx,
    output kill_ready, move_tick, spawn_valid, spawn_idx,
    output fly_alive_flat, wave_num, busy
  );
endinterface

// File: rtl/fly_wave_scheduler.sv
// Fly enemy wave sequencer: owns the per-slot alive mask and the move-step
// tick, releases slots one per SPAWN_GAP ticks, accepts kills, and starts
// the next wave after the field is empty and a pause of WAVE_PAUSE ticks.
module fly_wave_scheduler #(
  parameter int N_FLY      = 17,
  parameter int TICK_DIV   = 131072,
  parameter int SPAWN_GAP  = 8,
  parameter int WAVE_PAUSE = 64
) (
  input  logic clk25,
  input  logic rst,
  fly_wave_scheduler_if.slave bus
);

  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int GW = (SPAWN_GAP  > 1) ? $clog2(SPAWN_GAP)  : 1;
  localparam int QW = (WAVE_PAUSE > 1) ? $clog2(WAVE_PAUSE) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPAWN  = 2'd1,
    S_ACTIVE = 2'd2,
    S_PAUSE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick_q, tick_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [QW-1:0]    pause_q, pause_d;
  logic [4:0]       ptr_q, ptr_d;
  logic [N_FLY-1:0] alive_q, alive_d;
  logic             spawn_valid_q, spawn_valid_d;
  logic [4:0]       spawn_idx_q, spawn_idx_d;
  logic [7:0]       wave_q, wave_d;

  logic             busy;
  logic             kill_fire;
  logic [N_FLY-1:0] kill_mask;
  logic [N_FLY-1:0] spawn_mask;

  assign busy      = (state_q != S_IDLE);
  assign kill_fire = bus.kill_valid && busy;
  // A kill index at or beyond N_FLY shifts the one out of the mask, so
  // out-of-range kills are accepted and simply clear nothing.
  assign kill_mask  = kill_fire ? (N_FLY'(1) << bus.kill_idx) : '0;
  assign spawn_mask = N_FLY'(1) << ptr_q;

  // Next-state logic: prescaler, wave FSM, alive mask (clear then set, so a
  // same-cycle spawn beats a kill on the same slot).
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    tick_d        = 1'b0;
    gap_d         = gap_q;
    pause_d       = pause_q;
    ptr_d         = ptr_q;
    spawn_valid_d = 1'b0;
    spawn_idx_d   = spawn_idx_q;
    wave_d        = wave_q;
    alive_d       = alive_q & ~kill_mask;

    if (busy) begin
      tick_d  = (presc_q == PW'(TICK_DIV - 1));
      presc_d = tick_d ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SPAWN;
          presc_d = '0;
          wave_d  = '0;
          ptr_d   = '0;
          gap_d   = '0;
          pause_d = '0;
          alive_d = '0;
        end
      end
      S_SPAWN: begin
        if (tick_q) begin
          if (gap_q == GW'(SPAWN_GAP - 1)) begin
            gap_d         = '0;
            alive_d       = alive_d | spawn_mask;
            spawn_valid_d = 1'b1;
            spawn_idx_d   = ptr_q;
            ptr_d         = ptr_q + 5'd1;
            if (ptr_q == 5'(N_FLY - 1)) begin
              state_d = S_ACTIVE;
            end
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      S_ACTIVE: begin
        // Empty check uses the registered mask only, never the same-cycle kill.
        if (alive_q == '0) begin
          state_d = S_PAUSE;
          pause_d = '0;
        end
      end
      S_PAUSE: begin
        if (tick_q) begin
          if (pause_q == QW'(WAVE_PAUSE - 1)) begin
            state_d = S_SPAWN;
            ptr_d   = '0;
            gap_d   = '0;
            wave_d  = (wave_q == 8'hFF) ? 8'hFF : wave_q + 8'd1;
          end else begin
            pause_d = pause_q + QW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts everything at once.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      tick_q        <= 1'b0;
      gap_q         <= '0;
      pause_q       <= '0;
      ptr_q         <= '0;
      alive_q       <= '0;
      spawn_valid_q <= 1'b0;
      spawn_idx_q   <= '0;
      wave_q        <= '0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      gap_q         <= gap_d;
      pause_q       <= pause_d;
      ptr_q         <= ptr_d;
      alive_q       <= alive_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_idx_q   <= spawn_idx_d;
      wave_q        <= wave_d;
    end
  end

  assign bus.kill_ready     = busy;
  assign bus.busy           = busy;
  assign bus.move_tick      = tick_q;
  assign bus.spawn_valid    = spawn_valid_q;
  assign bus.spawn_idx      = spawn_idx_q;
  assign bus.fly_alive_flat = alive_q;
  assign bus.wave_num       = wave_q;

endmodule
